ewrapper_io_rx_deser: RTL and testbench
=======================================

Name: ewrapper_io_rx_deser

Overview:
- Receive-side deserializer for the 9-lane eLink: 8 data lanes plus 1 frame lane.
- Input is pre-captured DDR bit pairs (rising/falling sample per lane per fast cycle). Output is 72-bit parallel words.
- Recovers byte alignment from the frame lane, applying a one-UI bit slip when needed, and assembles one word every 4 fast cycles.
- Sits between the pin-level DDR capture and the RX protocol/decoder logic.

Parameters:
- LANES, 9, total lanes. Lane LANES-1 is the frame lane; lanes 0..LANES-2 carry data. Word width is 8*LANES.
- ERRCNT_W, 8, width of the saturating alignment-error counter.

Ports:
- CLK_IN  input  1  fast link clock; all logic on posedge.
- IO_RESET  input  1  asynchronous, active-high reset.
- rx_even  input  LANES  per-lane bit captured first in the cycle (earlier UI).
- rx_odd  input  LANES  per-lane bit captured second in the cycle (later UI).
- rx_enable  input  1  0 forces HUNT and suppresses output; synchronous.
- DATA_OUT_TO_DEVICE  output  8*LANES  assembled word; byte i = lane i, bit 7 = first UI.
- data_valid  output  1  one-cycle strobe, high for each emitted word.
- locked  output  1  high while in LOCKED.
- slip  output  1  current bit-slip setting (1 = word starts on odd UI).
- align_err_cnt  output  ERRCNT_W  saturating count of alignment errors.

Behaviour:
- Reset (async, IO_RESET=1): state=HUNT, DATA_OUT_TO_DEVICE=0, data_valid=0, locked=0, slip=0, align_err_cnt=0, phase counter=0, prev_odd=0, input stage=0.
- Stage 1: rx_even/rx_odd are registered every cycle. prev_odd holds the previous stage-1 odd vector.
- Slip mux:
  - slip=0: pair = (even, odd) from stage 1.
  - slip=1: pair = (prev_odd, even).
- HUNT, examining frame lane f of stage 1 and prev_odd:
  - prev_odd[f]=0, even[f]=1 → slip=0, phase=0. This pair is UI 7/6 of the word. Go LOCKED.
  - even[f]=0, odd[f]=1 → slip=1. The word starts with the next pair, phase=0. Go LOCKED one cycle later.
  - Both conditions true in the same cycle → the even-UI match wins (slip=0).
- LOCKED:
  - 2-bit phase counter increments each cycle and wraps 3→0.
  - Phase 0 pair → bits 7/6 of each byte; phase 1 → 5/4; phase 2 → 3/2; phase 3 → 1/0.
  - On phase 3 the full word is registered to DATA_OUT_TO_DEVICE.
  - Frame byte of that word (bits 8*LANES-1 : 8*LANES-8):
    - 0x00 → go HUNT, data_valid stays 0, DATA_OUT still updates.
    - 0xFF, or the first word after lock whose frame byte starts with 1s → data_valid=1 for one cycle.
    - Any other value on a non-first word → data_valid=1, align_err_cnt increments (saturates at all-ones), go HUNT.
- Latency: DATA_OUT_TO_DEVICE and data_valid update on the 5th posedge after the first pair of a word is presented on rx_even/rx_odd (slip=0). With slip=1 this is the 6th posedge.
- locked=1 exactly while state=LOCKED. slip holds its value until the next HUNT match.
- rx_enable=0: next edge state=HUNT, data_valid=0, phase=0. DATA_OUT_TO_DEVICE holds its value and the counter holds.
- Reset mid-word: the partial word is discarded; nothing is emitted.

Optional Feature:
- Macro: ELINK_RX_INVERT_EN.
- Defined: all LANES bits of rx_even/rx_odd are inverted at stage 1, before hunt and assembly, matching inverted-polarity targets.
- Undefined: no inversion. Reset values are identical in both builds.

Test Plan:
- Aligned lock: frame lane 0 for 4 cycles, then 1. Data lanes carry byte i = 0x10+i, MSB first, for 2 words, then frame 0 for 4 cycles → two data_valid pulses with DATA_OUT=0xFF171615_14131211_10. Then locked falls, no third pulse, slip=0.
- Slip lock: same stimulus with the frame rise on the odd UI and all data shifted one UI → identical words, slip=1, latency one cycle longer.
- Misaligned frame: locked, then frame byte 0xF0 → data_valid pulse, align_err_cnt 0→1, state HUNT. Repeat 300 times with ERRCNT_W=8 → counter stays at 255.
- rx_enable drop: deassert rx_enable at phase 2 mid-word → no data_valid, locked=0 next cycle; re-enable and re-frame → lock recovers.
- Async reset: assert IO_RESET between edges during LOCKED → all outputs 0 immediately; release → HUNT, no spurious valid.
- Build with ELINK_RX_INVERT_EN: drive bitwise-inverted stimulus from the aligned-lock case → identical outputs.

Source files
------------

// File: rtl/ewrapper_io_rx_deser.sv
// eLink RX deserializer: DDR bit pairs in, frame-aligned 8*LANES-bit words out.
// Optional build macro ELINK_RX_INVERT_EN inverts every input lane at the first stage.
module ewrapper_io_rx_deser #(
    parameter int unsigned LANES    = 9,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                 CLK_IN,
    input  logic                 IO_RESET,
    input  logic [LANES-1:0]     rx_even,
    input  logic [LANES-1:0]     rx_odd,
    input  logic                 rx_enable,
    output logic [8*LANES-1:0]   DATA_OUT_TO_DEVICE,
    output logic                 data_valid,
    output logic                 locked,
    output logic                 slip,
    output logic [ERRCNT_W-1:0]  align_err_cnt
);

    localparam int unsigned W = 8 * LANES;
    localparam int unsigned F = LANES - 1;

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e           state_q;
    logic [LANES-1:0] in_even, in_odd;
    logic [LANES-1:0] even_q, odd_q, prev_odd_q;
    logic [LANES-1:0] pair_hi, pair_lo;
    logic [1:0]       phase_q;
    logic             first_q;
    logic [W-1:0]     asm_q, word_next, hunt_word;
    logic [7:0]       byte_next [LANES];
    logic [7:0]       frame;
    logic             hunt_even, hunt_odd;

`ifdef ELINK_RX_INVERT_EN
    assign in_even = ~rx_even;
    assign in_odd  = ~rx_odd;
`else
    assign in_even = rx_even;
    assign in_odd  = rx_odd;
`endif

    // With slip set, a word starts on the odd UI: pair the held odd bit with the new even bit.
    assign pair_hi = slip ? prev_odd_q : even_q;
    assign pair_lo = slip ? even_q     : odd_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        always_comb begin
            byte_next[i] = asm_q[8*i +: 8];
            case (phase_q)
                2'd0:    byte_next[i][7:6] = {pair_hi[i], pair_lo[i]};
                2'd1:    byte_next[i][5:4] = {pair_hi[i], pair_lo[i]};
                2'd2:    byte_next[i][3:2] = {pair_hi[i], pair_lo[i]};
                default: byte_next[i][1:0] = {pair_hi[i], pair_lo[i]};
            endcase
        end
        assign word_next[8*i +: 8] = byte_next[i];
        assign hunt_word[8*i +: 8] = {even_q[i], odd_q[i], 6'b0};
    end

    assign frame     = word_next[W-1 -: 8];
    assign hunt_even = ~prev_odd_q[F] & even_q[F];
    assign hunt_odd  = ~even_q[F] & odd_q[F];
    assign locked    = (state_q == StLocked);

    always_ff @(posedge CLK_IN or posedge IO_RESET) begin
        if (IO_RESET) begin
            even_q             <= '0;
            odd_q              <= '0;
            prev_odd_q         <= '0;
            state_q            <= StHunt;
            phase_q            <= 2'd0;
            first_q            <= 1'b0;
            asm_q              <= '0;
            DATA_OUT_TO_DEVICE <= '0;
            data_valid         <= 1'b0;
            slip               <= 1'b0;
            align_err_cnt      <= '0;
        end else begin
            even_q     <= in_even;
            odd_q      <= in_odd;
            prev_odd_q <= odd_q;
            data_valid <= 1'b0;
            if (!rx_enable) begin
                state_q <= StHunt;
                phase_q <= 2'd0;
            end else begin
                case (state_q)
                    StHunt: begin
                        // Even-UI rise: the current pair already holds bits 7/6.
                        if (hunt_even) begin
                            slip    <= 1'b0;
                            asm_q   <= hunt_word;
                            phase_q <= 2'd1;
                            first_q <= 1'b1;
                            state_q <= StLocked;
                        end else if (hunt_odd) begin
                            slip    <= 1'b1;
                            phase_q <= 2'd0;
                            first_q <= 1'b1;
                            state_q <= StLocked;
                        end
                    end
                    default: begin
                        asm_q   <= word_next;
                        phase_q <= phase_q + 2'd1;
                        if (phase_q == 2'd3) begin
                            DATA_OUT_TO_DEVICE <= word_next;
                            first_q            <= 1'b0;
                            if (frame == 8'h00) begin
                                state_q <= StHunt;
                                phase_q <= 2'd0;
                            end else if (frame == 8'hFF || (first_q && frame[7])) begin
                                data_valid <= 1'b1;
                            end else begin
                                data_valid <= 1'b1;
                                if (align_err_cnt != '1) begin
                                    align_err_cnt <= align_err_cnt + ERRCNT_W'(1);
                                end
                                state_q <= StHunt;
                                phase_q <= 2'd0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ewrapper_io_rx_deser.sv
// Bench for ewrapper_io_rx_deser: UI-level stream stimulus, directed and model-based checks.
module tb_ewrapper_io_rx_deser;

    localparam int unsigned LANES    = 9;
    localparam int unsigned ERRCNT_W = 8;
    localparam int unsigned W        = 8 * LANES;
    localparam int          MAXP     = 2600;
    localparam int          PAD      = 12;
    localparam int          NE       = MAXP + PAD + 1;
    localparam int          CMAX     = (1 << ERRCNT_W) - 1;

    logic                CLK_IN = 1'b0;
    logic                IO_RESET;
    logic [LANES-1:0]    rx_even, rx_odd;
    logic                rx_enable;
    logic [W-1:0]        DATA_OUT_TO_DEVICE;
    logic                data_valid, locked, slip;
    logic [ERRCNT_W-1:0] align_err_cnt;

    ewrapper_io_rx_deser #(.LANES(LANES), .ERRCNT_W(ERRCNT_W)) dut (
        .CLK_IN             (CLK_IN),
        .IO_RESET           (IO_RESET),
        .rx_even            (rx_even),
        .rx_odd             (rx_odd),
        .rx_enable          (rx_enable),
        .DATA_OUT_TO_DEVICE (DATA_OUT_TO_DEVICE),
        .data_valid         (data_valid),
        .locked             (locked),
        .slip               (slip),
        .align_err_cnt      (align_err_cnt)
    );

    always #5 CLK_IN = ~CLK_IN;

    // UI stream: one entry per UI, bit LANES-1 is the frame lane.
    logic [LANES-1:0]    ui_a [2*(MAXP+PAD)];
    bit                  en_a [MAXP+PAD];
    int                  nu;

    logic [W-1:0]        o_data [NE];
    logic                o_valid [NE], o_locked [NE], o_slip [NE];
    logic [ERRCNT_W-1:0] o_cnt [NE];

    logic [W-1:0]        x_data [NE];
    logic                x_valid [NE], x_locked [NE], x_slip [NE];
    logic [ERRCNT_W-1:0] x_cnt [NE];
    bit                  x_dc [NE];

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] D1 = 64'h1716151413121110;
    localparam logic [W-1:0] EXP1 = {8'hFF, D1};

    task automatic clr_stream();
        nu = 0;
        for (int i = 0; i < 2*(MAXP+PAD); i++) ui_a[i] = '0;
        for (int i = 0; i < MAXP+PAD; i++) en_a[i] = 1'b1;
    endtask

    task automatic put_gap(input int n);
        for (int i = 0; i < n; i++) begin
            ui_a[nu] = '0;
            nu++;
        end
    endtask

    task automatic put_word(input logic [7:0] fr, input logic [63:0] d);
        for (int j = 0; j < 8; j++) begin
            ui_a[nu][LANES-1] = fr[7-j];
            for (int i = 0; i < LANES-1; i++) ui_a[nu][i] = d[8*i+7-j];
            nu++;
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK_IN);
        IO_RESET  = 1'b1;
        rx_even   = '0;
        rx_odd    = '0;
        rx_enable = 1'b1;
        repeat (2) @(negedge CLK_IN);
        IO_RESET = 1'b0;
    endtask

    // Pair k is presented before edge k+1; outputs after that edge land in slot k+1.
    task automatic drive_range(input int k0, input int k1);
        logic [LANES-1:0] e, o;
        for (int k = k0; k < k1; k++) begin
            e = ui_a[2*k];
            o = ui_a[2*k+1];
`ifdef ELINK_RX_INVERT_EN
            rx_even = ~e;
            rx_odd  = ~o;
`else
            rx_even = e;
            rx_odd  = o;
`endif
            rx_enable = en_a[k];
            @(posedge CLK_IN);
            @(negedge CLK_IN);
            o_data[k+1]   = DATA_OUT_TO_DEVICE;
            o_valid[k+1]  = data_valid;
            o_locked[k+1] = locked;
            o_slip[k+1]   = slip;
            o_cnt[k+1]    = align_err_cnt;
        end
    endtask

    function automatic logic fbit(input int t);
        return (t < 0) ? 1'b0 : ui_a[t][LANES-1];
    endfunction

    // Reference: scan the UI stream for frame rises, cut 8-UI words from there and apply the
    // frame-byte rules; a word's output edge follows the edge capturing its last UI by one.
    task automatic model_run(input int ne);
        int pos, u, w, ee, det, cnt, nui;
        logic [W-1:0] word;
        logic [7:0] fr;
        bit first, stop, done;
        for (int e = 0; e <= ne; e++) begin
            x_valid[e] = 1'b0; x_data[e] = '0; x_locked[e] = 1'b0;
            x_slip[e] = 1'b0; x_cnt[e] = '0; x_dc[e] = 1'b0;
        end
        cnt = 0; pos = 0; stop = 1'b0; nui = 2 * ne;
        while (!stop) begin
            u = -1;
            for (int t = 2*pos; t < nui && u < 0; t++)
                if (fbit(t) && !fbit(t-1)) u = t;
            if (u < 0) begin
                stop = 1'b1;
            end else begin
                det = u / 2 + 2;
                for (int e = det; e <= ne; e++) begin
                    x_locked[e] = 1'b1;
                    x_slip[e]   = (u % 2 == 1);
                end
                if (det <= ne) x_dc[det] = 1'b1;
                w = u; first = 1'b1; done = 1'b0;
                while (!done) begin
                    ee = (w + 7) / 2 + 2;
                    if (ee > ne || w + 7 >= nui) begin
                        stop = 1'b1; done = 1'b1;
                    end else begin
                        word = '0;
                        for (int j = 0; j < 8; j++)
                            for (int i = 0; i < LANES; i++) word[8*i+7-j] = ui_a[w+j][i];
                        fr = word[W-1 -: 8];
                        for (int e = ee; e <= ne; e++) x_data[e] = word;
                        if (fr == 8'h00) begin
                            for (int e = ee; e <= ne; e++) x_locked[e] = 1'b0;
                            pos = ee - 1; done = 1'b1;
                        end else begin
                            x_valid[ee] = 1'b1;
                            if (fr == 8'hFF || (first && fr[7])) begin
                                first = 1'b0; w += 8;
                            end else begin
                                if (cnt < CMAX) cnt++;
                                for (int e = ee; e <= ne; e++) begin
                                    x_cnt[e] = ERRCNT_W'(cnt);
                                    x_locked[e] = 1'b0;
                                end
                                pos = ee - 1; done = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        IO_RESET = 1'b1; rx_even = '0; rx_odd = '0; rx_enable = 1'b1;
        #1;
        checks++; if (DATA_OUT_TO_DEVICE !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", DATA_OUT_TO_DEVICE); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", data_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b expected 0", locked); end
        checks++; if (slip !== 1'b0) begin errors++; $display("FAIL reset_slip got %b expected 0", slip); end
        checks++; if (align_err_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d expected 0", align_err_cnt); end
        apply_reset();
    endtask

    task automatic test_aligned();
        int np, nv;
        clr_stream(); put_gap(8); put_word(8'hFF, D1); put_word(8'hFF, D1); put_word(8'h00, 64'h0);
        np = nu / 2;
        apply_reset(); drive_range(0, np + PAD);
        nv = 0;
        for (int e = 1; e <= np + PAD; e++) if (o_valid[e] === 1'b1) nv++;
        checks++; if (nv != 2) begin errors++; $display("FAIL aligned_nvalid got %0d expected 2", nv); end
        checks++; if (o_valid[9] !== 1'b1) begin errors++; $display("FAIL aligned_valid9 got %b expected 1", o_valid[9]); end
        checks++; if (o_data[9] !== EXP1) begin errors++; $display("FAIL aligned_data9 got %h expected %h", o_data[9], EXP1); end
        checks++; if (o_valid[13] !== 1'b1) begin errors++; $display("FAIL aligned_valid13 got %b expected 1", o_valid[13]); end
        checks++; if (o_data[13] !== EXP1) begin errors++; $display("FAIL aligned_data13 got %h expected %h", o_data[13], EXP1); end
        checks++; if (o_locked[16] !== 1'b1) begin errors++; $display("FAIL aligned_locked16 got %b expected 1", o_locked[16]); end
        checks++; if (o_locked[17] !== 1'b0) begin errors++; $display("FAIL aligned_locked17 got %b expected 0", o_locked[17]); end
        checks++; if (o_data[17] !== '0) begin errors++; $display("FAIL aligned_data17 got %h expected 0", o_data[17]); end
        checks++; if (o_slip[16] !== 1'b0) begin errors++; $display("FAIL aligned_slip got %b expected 0", o_slip[16]); end
    endtask

    task automatic test_slip();
        int np, nv;
        clr_stream(); put_gap(9); put_word(8'hFF, D1); put_word(8'hFF, D1); put_word(8'h00, 64'h0);
        put_gap(1);
        np = nu / 2;
        apply_reset(); drive_range(0, np + PAD);
        nv = 0;
        for (int e = 1; e <= np + PAD; e++) if (o_valid[e] === 1'b1) nv++;
        checks++; if (nv != 2) begin errors++; $display("FAIL slip_nvalid got %0d expected 2", nv); end
        checks++; if (o_valid[9] !== 1'b0) begin errors++; $display("FAIL slip_valid9 got %b expected 0", o_valid[9]); end
        checks++; if (o_valid[10] !== 1'b1) begin errors++; $display("FAIL slip_valid10 got %b expected 1", o_valid[10]); end
        checks++; if (o_data[10] !== EXP1) begin errors++; $display("FAIL slip_data10 got %h expected %h", o_data[10], EXP1); end
        checks++; if (o_data[14] !== EXP1) begin errors++; $display("FAIL slip_data14 got %h expected %h", o_data[14], EXP1); end
        checks++; if (o_slip[10] !== 1'b1) begin errors++; $display("FAIL slip_slip10 got %b expected 1", o_slip[10]); end
        checks++; if (o_locked[18] !== 1'b0) begin errors++; $display("FAIL slip_locked18 got %b expected 0", o_locked[18]); end
        checks++; if (o_slip[20] !== 1'b1) begin errors++; $display("FAIL slip_hold got %b expected 1", o_slip[20]); end
    endtask

    task automatic test_misalign_sat();
        int np, nv;
        clr_stream(); put_gap(2);
        for (int r = 0; r < 300; r++) begin
            put_word(8'hFF, {$urandom, $urandom});
            put_word(8'hF0, {$urandom, $urandom});
        end
        put_word(8'h00, 64'h0);
        np = nu / 2;
        apply_reset(); drive_range(0, np + PAD);
        nv = 0;
        for (int e = 1; e <= np + PAD; e++) if (o_valid[e] === 1'b1) nv++;
        checks++; if (o_cnt[9] !== 8'd0) begin errors++; $display("FAIL sat_cnt9 got %0d expected 0", o_cnt[9]); end
        checks++; if (o_valid[10] !== 1'b1) begin errors++; $display("FAIL sat_valid10 got %b expected 1", o_valid[10]); end
        checks++; if (o_cnt[10] !== 8'd1) begin errors++; $display("FAIL sat_cnt10 got %0d expected 1", o_cnt[10]); end
        checks++; if (o_locked[10] !== 1'b0) begin errors++; $display("FAIL sat_locked10 got %b expected 0", o_locked[10]); end
        checks++; if (o_cnt[2034] !== 8'd254) begin errors++; $display("FAIL sat_cnt254 got %0d expected 254", o_cnt[2034]); end
        checks++; if (o_cnt[2042] !== 8'd255) begin errors++; $display("FAIL sat_cnt255 got %0d expected 255", o_cnt[2042]); end
        checks++; if (o_cnt[np+PAD] !== 8'd255) begin errors++; $display("FAIL sat_cnt_end got %0d expected 255", o_cnt[np+PAD]); end
        checks++; if (nv != 600) begin errors++; $display("FAIL sat_nvalid got %0d expected 600", nv); end
    endtask

    task automatic test_enable_drop();
        int np, nv;
        logic [63:0] d2;
        d2 = {$urandom, $urandom};
        clr_stream(); put_gap(8); put_word(8'hFF, D1); put_gap(8); put_word(8'hFF, d2);
        put_word(8'h00, 64'h0);
        np = nu / 2;
        en_a[7] = 1'b0; en_a[8] = 1'b0;
        apply_reset(); drive_range(0, np + PAD);
        nv = 0;
        for (int e = 1; e <= 16; e++) if (o_valid[e] === 1'b1) nv++;
        checks++; if (o_locked[7] !== 1'b1) begin errors++; $display("FAIL en_locked7 got %b expected 1", o_locked[7]); end
        checks++; if (o_locked[8] !== 1'b0) begin errors++; $display("FAIL en_locked8 got %b expected 0", o_locked[8]); end
        checks++; if (nv != 0) begin errors++; $display("FAIL en_nvalid got %0d expected 0", nv); end
        checks++; if (o_data[12] !== '0) begin errors++; $display("FAIL en_data_hold got %h expected 0", o_data[12]); end
        checks++; if (o_locked[16] !== 1'b1) begin errors++; $display("FAIL en_relock got %b expected 1", o_locked[16]); end
        checks++; if (o_valid[17] !== 1'b1) begin errors++; $display("FAIL en_valid17 got %b expected 1", o_valid[17]); end
        checks++; if (o_data[17] !== {8'hFF, d2}) begin errors++; $display("FAIL en_data17 got %h expected %h", o_data[17], {8'hFF, d2}); end
    endtask

    task automatic test_async_reset();
        int nv, nl;
        clr_stream(); put_gap(9); put_word(8'hFF, D1); put_word(8'hFF, D1); put_word(8'h00, 64'h0);
        apply_reset(); drive_range(0, 12);
        checks++; if (o_data[10] !== EXP1) begin errors++; $display("FAIL ar_data10 got %h expected %h", o_data[10], EXP1); end
        checks++; if (o_locked[12] !== 1'b1 || o_slip[12] !== 1'b1) begin errors++; $display("FAIL ar_prelock got %b%b expected 11", o_locked[12], o_slip[12]); end
        #2 IO_RESET = 1'b1;
        #1;
        checks++; if (DATA_OUT_TO_DEVICE !== '0) begin errors++; $display("FAIL ar_data got %h expected 0", DATA_OUT_TO_DEVICE); end
        checks++; if (locked !== 1'b0 || slip !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL ar_flags got %b%b%b expected 000", locked, slip, data_valid); end
        checks++; if (align_err_cnt !== '0) begin errors++; $display("FAIL ar_cnt got %0d expected 0", align_err_cnt); end
        @(negedge CLK_IN);
        IO_RESET = 1'b0;
        clr_stream();
        drive_range(0, 12);
        nv = 0; nl = 0;
        for (int e = 1; e <= 12; e++) begin
            if (o_valid[e] !== 1'b0) nv++;
            if (o_locked[e] !== 1'b0) nl++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL ar_spurious_valid got %0d expected 0", nv); end
        checks++; if (nl != 0) begin errors++; $display("FAIL ar_spurious_lock got %0d expected 0", nl); end
    endtask

    task automatic test_random();
        int np, ne, nw, r;
        logic [7:0] fr;
        for (int it = 0; it < 4; it++) begin
            clr_stream();
            put_gap($urandom_range(0, 7));
            for (int s = 0; s < 4; s++) begin
                nw = $urandom_range(1, 4);
                put_word(8'hFF, {$urandom, $urandom});
                for (int k = 1; k < nw; k++) begin
                    r = $urandom_range(0, 3);
                    fr = (r == 0) ? 8'hFF : (r == 1) ? 8'hF0 : (r == 2) ? 8'($urandom) : 8'h00;
                    put_word(fr, {$urandom, $urandom});
                end
                put_word(8'h00, {$urandom, $urandom});
                put_gap($urandom_range(0, 5));
            end
            put_gap(16);
            if (nu % 2 == 1) put_gap(1);
            np = nu / 2;
            ne = np + PAD;
            apply_reset(); drive_range(0, ne);
            model_run(ne);
            for (int e = 1; e <= ne; e++) begin
                checks++;
                if (o_valid[e] !== x_valid[e]) begin errors++; $display("FAIL rnd_valid it %0d edge %0d got %b expected %b", it, e, o_valid[e], x_valid[e]); end
                checks++;
                if (o_data[e] !== x_data[e]) begin errors++; $display("FAIL rnd_data it %0d edge %0d got %h expected %h", it, e, o_data[e], x_data[e]); end
                checks++;
                if (o_cnt[e] !== x_cnt[e]) begin errors++; $display("FAIL rnd_cnt it %0d edge %0d got %0d expected %0d", it, e, o_cnt[e], x_cnt[e]); end
                if (!x_dc[e]) begin
                    checks++;
                    if (o_locked[e] !== x_locked[e]) begin errors++; $display("FAIL rnd_locked it %0d edge %0d got %b expected %b", it, e, o_locked[e], x_locked[e]); end
                    checks++;
                    if (o_slip[e] !== x_slip[e]) begin errors++; $display("FAIL rnd_slip it %0d edge %0d got %b expected %b", it, e, o_slip[e], x_slip[e]); end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned();
        test_slip();
        test_misalign_sat();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
